// File: rtl/isr_pkg.sv
// rtl/isr_pkg.sv - shared shift-register constants and length decode
package isr_pkg;

    localparam int SR_WIDTH       = 32;
    localparam int SR_COUNT_WIDTH = 6;

    // 5-bit length field: 0 means a full 32-bit transfer.
    function automatic logic [SR_COUNT_WIDTH-1:0] decode_len(input logic [4:0] field);
        decode_len = (field == 5'd0) ? 6'd32 : {1'b0, field};
    endfunction

endpackage

// File: rtl/isr.sv
// rtl/isr.sv - PIO input shift register with shift count and autopush request
//
// Ports:
//   clk, reset             clock, synchronous active-low reset
//   in_shiftDirection      1 = shift right (bits enter at MSB), 0 = shift left
//   in_data                IN source bits, low in_bitReqLength bits used
//   in_inEnable            perform an IN this cycle
//   in_bitReqLength        bits per IN (0 = 32)
//   in_pushNow             register contents taken by RX FIFO; clear state
//   in_autoPushEnable      gates out_requestPush
//   in_pushThreshold       autopush threshold (0 = 32)
//   out_data               register contents (RX FIFO write data)
//   out_shiftCount         bits accumulated, 0..32
//   out_full               threshold reached
//   out_requestPush        autopush request
module isr
    import isr_pkg::*;
(
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_shiftDirection,
    input  logic [SR_WIDTH-1:0]       in_data,
    input  logic                      in_inEnable,
    input  logic [4:0]                in_bitReqLength,
    input  logic                      in_pushNow,
    input  logic                      in_autoPushEnable,
    input  logic [4:0]                in_pushThreshold,
    output logic [SR_WIDTH-1:0]       out_data,
    output logic [SR_COUNT_WIDTH-1:0] out_shiftCount,
    output logic                      out_full,
    output logic                      out_requestPush
);

    logic [SR_WIDTH-1:0]       reg_data;
    logic [SR_COUNT_WIDTH-1:0] reg_shiftCount;

    logic [SR_COUNT_WIDTH-1:0] n;
    logic                      n_full;
    logic [4:0]                n_lo;
    logic [4:0]                r_amt;
    logic [SR_WIDTH-1:0]       mask;
    logic [SR_WIDTH-1:0]       src;
    logic [SR_WIDTH-1:0]       base_data;
    logic [SR_COUNT_WIDTH-1:0] base_count;
    logic [6:0]                sum;
    logic [SR_WIDTH-1:0]       next_data;
    logic [SR_COUNT_WIDTH-1:0] next_count;

    always_comb begin
        n          = decode_len(in_bitReqLength);
        n_full     = (n == 6'd32);
        n_lo       = n[4:0];
        // Right shift places the new bits at the top: shift src up by 32-n.
        r_amt      = 5'(6'd32 - n);
        mask       = n_full ? '1 : ((32'd1 << n_lo) - 32'd1);
        src        = in_data & mask;
        // A push this cycle hands the old contents to the FIFO, so any
        // merged IN starts from an empty register.
        base_data  = in_pushNow ? '0 : reg_data;
        base_count = in_pushNow ? '0 : reg_shiftCount;
        sum        = {1'b0, base_count} + {1'b0, n};

        next_data  = base_data;
        next_count = base_count;
        if (in_inEnable) begin
            if (n_full)
                next_data = src;
            else if (in_shiftDirection)
                next_data = (base_data >> n_lo) | (src << r_amt);
            else
                next_data = (base_data << n_lo) | src;
            next_count = (sum > 7'd32) ? 6'd32 : sum[5:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            reg_data       <= '0;
            reg_shiftCount <= '0;
        end else begin
            reg_data       <= next_data;
            reg_shiftCount <= next_count;
        end
    end

    assign out_data        = reg_data;
    assign out_shiftCount  = reg_shiftCount;
    assign out_full        = ((in_pushThreshold != 5'd0) &&
                              (reg_shiftCount >= {1'b0, in_pushThreshold})) ||
                             (reg_shiftCount >= 6'd32);
    assign out_requestPush = out_full & in_autoPushEnable;

endmodule
